// File: rtl/line_mem_bridge.sv
// Line bridge: serialises 1024-bit I/D line transfers onto a 64-bit single-port SRAM.
// Define LMB_DATA_PRIO_EN to give the D-port fixed priority over the I-port on reads.
module line_mem_bridge #(
   parameter int          ADDR_W    = 12,
   parameter logic [63:0] IMEM_BASE = 64'h8000_0000,
   parameter logic [63:0] DMEM_BASE = 64'h0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [63:0]       b_addr_i,
   output logic [1023:0]     b_data_i,
   input  logic              b_rd_i,
   output logic              b_dv_i,
   input  logic [63:0]       b_addr,
   output logic [1023:0]     b_data_in,
   input  logic              b_rd,
   output logic              b_dv,
   input  logic [1023:0]     b_data_out,
   input  logic              b_wr,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [63:0]       m_wdata,
   input  logic [63:0]       m_rdata
);

   typedef enum logic [2:0] {IDLE, WDRAIN, RISSUE, RRESP, DONE} state_t;

   state_t            state;
   logic [4:0]        beat;
   logic              wbuf_vld;
   logic              ack_pend;
   logic              sel_d;
   logic              cap_vld_p1;
   logic [3:0]        cap_idx_p1;
   logic [ADDR_W-1:0] line_word_q;
   logic [1023:0]     wbuf;
   logic [959:0]      line_buf;
   logic              pick_d;
   logic [ADDR_W-1:0] rd_word;
   logic [ADDR_W-1:0] wr_word;
   logic              idle_free;

   // First word of the 128-byte line holding addr, wrapped to the memory size.
   function automatic logic [ADDR_W-1:0] line_word(input logic [63:0] addr, input logic [63:0] base);
      return ADDR_W'(((addr - base) >> 3) & ~64'hF);
   endfunction

`ifdef LMB_DATA_PRIO_EN
   assign pick_d = b_rd;
`else
   logic rr_d;
   assign pick_d = b_rd & (~b_rd_i | rr_d);
`endif

   assign rd_word   = pick_d ? line_word(b_addr, DMEM_BASE) : line_word(b_addr_i, IMEM_BASE);
   assign wr_word   = line_word(b_addr, DMEM_BASE);
   assign idle_free = (state == IDLE) && !wbuf_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         beat       <= '0;
         wbuf_vld   <= 1'b0;
         ack_pend   <= 1'b0;
         sel_d      <= 1'b0;
         cap_vld_p1 <= 1'b0;
         m_en       <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         b_dv       <= 1'b0;
         b_dv_i     <= 1'b0;
         b_data_i   <= '0;
         b_data_in  <= '0;
`ifndef LMB_DATA_PRIO_EN
         rr_d       <= 1'b1;
`endif
      end else begin
         b_dv       <= 1'b0;
         b_dv_i     <= 1'b0;
         cap_vld_p1 <= m_en & ~m_we;
         case (state)
            IDLE: begin
               if (wbuf_vld) begin
                  beat  <= '0;
                  state <= WDRAIN;
               end else if (b_wr) begin
                  wbuf_vld <= 1'b1;
                  ack_pend <= 1'b1;
                  beat     <= '0;
                  state    <= WDRAIN;
               end else if (b_rd | b_rd_i) begin
                  sel_d  <= pick_d;
                  m_en   <= 1'b1;
                  m_we   <= 1'b0;
                  m_addr <= rd_word;
                  beat   <= 5'd1;
                  state  <= RISSUE;
`ifndef LMB_DATA_PRIO_EN
                  if (b_rd & b_rd_i)
                     rr_d <= ~rr_d;
`endif
               end
            end
            WDRAIN: begin
               // The write is acknowledged on the first drain cycle; the drain itself carries on.
               b_dv     <= ack_pend;
               ack_pend <= 1'b0;
               if (beat != 5'd16) begin
                  m_en    <= 1'b1;
                  m_we    <= 1'b1;
                  m_addr  <= line_word_q + ADDR_W'(beat);
                  m_wdata <= wbuf[{beat[3:0], 6'd0} +: 64];
                  beat    <= beat + 5'd1;
               end else begin
                  m_en     <= 1'b0;
                  m_we     <= 1'b0;
                  wbuf_vld <= 1'b0;
                  state    <= IDLE;
               end
            end
            RISSUE: begin
               if (beat != 5'd16) begin
                  m_addr <= line_word_q + ADDR_W'(beat);
                  beat   <= beat + 5'd1;
               end else begin
                  m_en <= 1'b0;
               end
               // Last beat arrives straight from memory and goes out with the buffered 15.
               if (cap_vld_p1 && cap_idx_p1 == 4'd15) begin
                  state <= RRESP;
                  if (sel_d) begin
                     b_dv      <= 1'b1;
                     b_data_in <= {m_rdata, line_buf};
                  end else begin
                     b_dv_i   <= 1'b1;
                     b_data_i <= {m_rdata, line_buf};
                  end
               end
            end
            RRESP: begin
               b_data_i  <= '0;
               b_data_in <= '0;
               state     <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // ---- p1: read-data capture and line/write buffers (data only, no reset) ----
   always_ff @(posedge clk) begin
      cap_idx_p1 <= m_addr[3:0];
      if (cap_vld_p1 && cap_idx_p1 != 4'd15)
         line_buf[{cap_idx_p1, 6'd0} +: 64] <= m_rdata;
      if (idle_free) begin
         if (b_wr) begin
            wbuf        <= b_data_out;
            line_word_q <= wr_word;
         end else if (b_rd | b_rd_i) begin
            line_word_q <= rd_word;
         end
      end
   end

endmodule

// File: doc/line_mem_bridge.md
Name: line_mem_bridge

Overview:
- Memory-side bridge directly downstream of the hart's instruction and data line buses.
- Services 1024-bit (128-byte) line reads on the I-port and the D-port, and line writes on the D-port.
- Arbitrates between the two ports and serialises each line into 16 beats of 64 bits to a single-port synchronous word memory.
- Replaces the behavioural bus models so the hart can run against a plain SRAM.

Parameters:
- ADDR_W, 12: memory word-address width (words are 64-bit).
- IMEM_BASE, 64'h80000000: base subtracted from I-port byte addresses.
- DMEM_BASE, 64'h0: base subtracted from D-port byte addresses.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- b_addr_i  in  64  I-port byte address.
- b_data_i  out  1024  I-port line data.
- b_rd_i  in  1  I-port read request; level, held until b_dv_i.
- b_dv_i  out  1  I-port data valid; one-cycle pulse.
- b_addr  in  64  D-port byte address.
- b_data_in  out  1024  D-port read line data.
- b_rd  in  1  D-port read request; level, held until b_dv.
- b_dv  out  1  D-port done; one-cycle pulse for a read or a write.
- b_data_out  in  1024  D-port write line.
- b_wr  in  1  D-port write request; level, held until b_dv.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable; qualified by m_en.
- m_addr  out  ADDR_W  memory word address.
- m_wdata  out  64  memory write data.
- m_rdata  in  64  memory read data, valid the cycle after an m_en read.

Behaviour:
- Reset values: all outputs 0. FSM enters IDLE, write buffer is empty, round-robin pointer points to D.
- Address mapping: line = (addr - BASE) with bits [6:0] cleared. Word address for beat k is ((line >> 3) + k), truncated to ADDR_W bits; wrap-around is silent.
- Data mapping: beat k covers line bits [64k+63:64k], i.e. bytes 8k..8k+7, little-endian.
- b_data_i and b_data_in are zero whenever their dv output is low.
- FSM states:
  - IDLE: samples requests. Priority order:
    - Write buffer non-empty → WDRAIN.
    - Else b_wr → capture the line and its address into the write buffer, pulse b_dv on the next cycle, then → WDRAIN.
    - Else read request(s) → RISSUE.
  - Read arbitration: if both ports request, the round-robin pointer decides and then flips to the other port. If only one port requests, it is served and the pointer is left unchanged.
  - WDRAIN: 16 cycles with m_en = m_we = 1, beats 0..15 in order; then → IDLE with the buffer empty.
  - RISSUE: 16 cycles with m_en = 1, m_we = 0; m_rdata for beat k is captured on the edge after its issue.
  - RRESP: assert the selected port's dv for exactly one cycle, with the full line on its data bus; then → DONE.
  - DONE: one cycle in which requests are ignored, giving the requester time to drop its level; then → IDLE.
- Read latency: request sampled at edge N → dv high from edge N+17 to N+18.
- Write acknowledge: b_wr sampled at edge N → b_dv high from N+1 to N+2, while the drain runs in parallel. A read is never issued before the drain completes, so read-after-write is always coherent.
- A request held while the bridge is busy stays pending and is served later; it is never lost.
- b_rd and b_wr asserted together on the D-port: the write is served first.
- Reset mid-operation: abort immediately, discard the buffer and any partial line, no dv pulse.
- m_en is never high in IDLE, RRESP or DONE.

Optional Feature:
- Macro: LMB_DATA_PRIO_EN.
- Defined: the D-port always wins a simultaneous read; the round-robin pointer is removed.
- Undefined: round-robin arbitration as specified above.

Test Plan:
- I-read: b_rd_i = 1, b_addr_i = 64'h80000080, memory words 16..31 preloaded with value k → b_dv_i pulses at cycle 17; b_data_i[64k +: 64] = 16 + k; exactly 16 m_en cycles with m_addr 16..31.
- D-write then read: b_wr at addr 64'h100 with a known pattern, followed by b_rd at the same addr → b_dv at cycle 1; m_we beats at addresses 32..47; the read returns an identical line with no stale beat.
- Simultaneous reads: b_rd and b_rd_i asserted together, three times back-to-back → service order D, I, D with the macro undefined; D, D, D with LMB_DATA_PRIO_EN defined.
- Wrap: b_addr = 64'h7F80 with ADDR_W = 12 → m_addr runs 4080..4095 and the line is returned correctly.
- Reset mid-read: rst_n low at beat 5 of RISSUE → all outputs 0 immediately; no dv pulse; a fresh request after release completes in 17 cycles.
